// File: rtl/parking_gate_ctrl.sv
// parking_gate_ctrl: occupancy counter and shared-barrier arbiter
// for a single-lane parking lot.
module parking_gate_ctrl #(
    parameter int CAPACITY = 8,
    parameter int CNT_W    = 4,
    parameter int TIMEOUT  = 50,
    parameter int TO_W     = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_in,
    input  logic             req_out,
    input  logic             entering,
    input  logic             exiting,
    output logic             gate_open,
    output logic             grant_in,
    output logic             grant_out,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             violation,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] CAP_V = CNT_W'(CAPACITY);
    localparam logic [TO_W-1:0]  T_MAX = TO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GRANT_IN  = 2'd1,
        GRANT_OUT = 2'd2
    } state_t;

    typedef enum logic {
        SRV_OUT = 1'b0,
        SRV_IN  = 1'b1
    } srv_t;

    state_t           state;
    srv_t             last_srv;
    logic [TO_W-1:0]  timer;
    logic [CNT_W-1:0] next_count;
    logic             elig_in;
    logic             elig_out;
    logic             pick_in;
    logic             unauth;
    logic             expired;

    assign full      = (count == CAP_V);
    assign empty     = (count == '0);
    assign gate_open = grant_in | grant_out;

    // Request eligibility, tie-break and pass authorization.
    always_comb begin
        elig_in  = req_in & ~full;
        elig_out = req_out;
        pick_in  = elig_in & (~elig_out | (last_srv == SRV_OUT));
        unauth   = (entering & (state != GRANT_IN))
                 | (exiting & (state != GRANT_OUT));
        expired  = (timer == T_MAX);
    end

    // Saturating occupancy update; opposite pulses cancel out.
    always_comb begin
        next_count = count;
        if (entering && !exiting && count != CAP_V) begin
            next_count = count + 1'b1;
        end else if (exiting && !entering && count != '0) begin
            next_count = count - 1'b1;
        end
    end

    // Gate arbitration FSM with registered grants and pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            last_srv  <= SRV_OUT;
            timer     <= '0;
            count     <= '0;
            grant_in  <= 1'b0;
            grant_out <= 1'b0;
            violation <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            count     <= next_count;
            violation <= unauth;
            timeout   <= 1'b0;
            unique case (state)
                IDLE: begin
                    timer <= '0;
                    if (pick_in) begin
                        state    <= GRANT_IN;
                        grant_in <= 1'b1;
                    end else if (elig_out) begin
                        state     <= GRANT_OUT;
                        grant_out <= 1'b1;
                    end
                end
                GRANT_IN: begin
                    if (entering || expired) begin
                        state    <= IDLE;
                        grant_in <= 1'b0;
                        last_srv <= SRV_IN;
                        timer    <= '0;
                        timeout  <= ~entering;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                GRANT_OUT: begin
                    if (exiting || expired) begin
                        state     <= IDLE;
                        grant_out <= 1'b0;
                        last_srv  <= SRV_OUT;
                        timer     <= '0;
                        timeout   <= ~exiting;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    grant_in  <= 1'b0;
                    grant_out <= 1'b0;
                    timer     <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// tb_parking_gate_ctrl: directed plus random stimulus checked
// against a behavioural model of the lot and its barrier.
module tb_parking_gate_ctrl;

    localparam int CAP = 8;
    localparam int TO  = 50;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_in;
    logic       req_out;
    logic       entering;
    logic       exiting;
    logic       gate_open;
    logic       grant_in;
    logic       grant_out;
    logic [3:0] count;
    logic       full;
    logic       empty;
    logic       violation;
    logic       timeout;

    int n_assert = 0;
    int n_fail   = 0;

    // Model: who holds the gate (0 none, +1 entry, -1 exit),
    // how long it has been held, cars inside, last served side.
    int owner;
    int age;
    int mcount;
    bit last_in;
    bit m_viol;
    bit m_to;

    always #5 clk = ~clk;

    parking_gate_ctrl #(
        .CAPACITY(CAP),
        .CNT_W   (4),
        .TIMEOUT (TO),
        .TO_W    (6)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req_in   (req_in),
        .req_out  (req_out),
        .entering (entering),
        .exiting  (exiting),
        .gate_open(gate_open),
        .grant_in (grant_in),
        .grant_out(grant_out),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .violation(violation),
        .timeout  (timeout)
    );

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("grant_in", 32'(grant_in), 32'(owner == 1));
        chk("grant_out", 32'(grant_out), 32'(owner == -1));
        chk("gate_open", 32'(gate_open), 32'(owner != 0));
        chk("count", 32'(count), 32'(mcount));
        chk("full", 32'(full), 32'(mcount == CAP));
        chk("empty", 32'(empty), 32'(mcount == 0));
        chk("violation", 32'(violation), 32'(m_viol));
        chk("timeout", 32'(timeout), 32'(m_to));
    endtask

    task automatic model_reset();
        owner   = 0;
        age     = 0;
        mcount  = 0;
        last_in = 1'b0;
        m_viol  = 1'b0;
        m_to    = 1'b0;
    endtask

    task automatic model_next();
        int nc;
        bit want_in;
        bit want_out;
        bit done;
        m_viol = (entering && owner != 1) || (exiting && owner != -1);
        m_to   = 1'b0;
        nc = mcount + int'(entering) - int'(exiting);
        if (nc < 0) nc = 0;
        if (nc > CAP) nc = CAP;
        if (owner == 0) begin
            want_in  = req_in && (mcount < CAP);
            want_out = req_out;
            if (want_in && want_out) owner = last_in ? -1 : 1;
            else if (want_in) owner = 1;
            else if (want_out) owner = -1;
            age = 0;
        end else begin
            done = (owner == 1) ? entering : exiting;
            if (done || age == TO - 1) begin
                m_to    = !done;
                last_in = (owner == 1);
                owner   = 0;
            end else begin
                age++;
            end
        end
        mcount = nc;
    endtask

    task automatic step();
        model_next();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_entry();
        req_in = 1'b1;
        step();
        req_in = 1'b0;
        step();
        entering = 1'b1;
        step();
        entering = 1'b0;
        step();
    endtask

    task automatic do_exit();
        req_out = 1'b1;
        step();
        req_out = 1'b0;
        step();
        exiting = 1'b1;
        step();
        exiting = 1'b0;
        step();
    endtask

    initial begin
        int opens;
        int tos;
        int pden;
        reset    = 1'b1;
        req_in   = 1'b0;
        req_out  = 1'b0;
        entering = 1'b0;
        exiting  = 1'b0;
        model_reset();
        #2;
        check_all();
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Single entry, pulse three cycles into the grant.
        req_in = 1'b1;
        step();
        req_in = 1'b0;
        chk("first_grant", 32'(grant_in), 32'd1);
        step();
        step();
        entering = 1'b1;
        step();
        entering = 1'b0;
        chk("count_after_entry", 32'(count), 32'd1);
        step();

        // Reach count 2 with exit served last, then a held tie.
        do_entry();
        do_entry();
        do_exit();
        req_in  = 1'b1;
        req_out = 1'b1;
        step();
        chk("tie_entry_first", 32'(grant_in), 32'd1);
        req_in   = 1'b0;
        entering = 1'b1;
        step();
        entering = 1'b0;
        chk("tie_idle_gap", 32'(gate_open), 32'd0);
        step();
        chk("tie_exit_second", 32'(grant_out), 32'd1);
        req_out = 1'b0;
        exiting = 1'b1;
        step();
        exiting = 1'b0;
        chk("tie_count", 32'(count), 32'd2);
        step();

        // Fill the lot, then entry must wait for an exit.
        for (int i = 0; i < 12 && mcount < CAP; i++) do_entry();
        chk("filled", 32'(full), 32'd1);
        req_in = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("full_no_grant", 32'(gate_open), 32'd0);
        req_out = 1'b1;
        step();
        req_out = 1'b0;
        exiting = 1'b1;
        step();
        exiting = 1'b0;
        step();
        step();
        chk("entry_after_exit", 32'(grant_in), 32'd1);
        req_in   = 1'b0;
        entering = 1'b1;
        step();
        entering = 1'b0;
        step();

        // Entry grant with no pulse must time out after 50 cycles.
        do_exit();
        opens = 0;
        tos   = 0;
        req_in = 1'b1;
        step();
        req_in = 1'b0;
        if (gate_open) opens++;
        for (int i = 0; i < 60; i++) begin
            step();
            if (gate_open) opens++;
            if (timeout) tos++;
        end
        chk("open_cycles", 32'(opens), 32'd50);
        chk("timeout_pulses", 32'(tos), 32'd1);
        req_in  = 1'b1;
        req_out = 1'b1;
        step();
        chk("tie_after_timeout", 32'(grant_out), 32'd1);
        req_in  = 1'b0;
        req_out = 1'b0;
        exiting = 1'b1;
        step();
        exiting = 1'b0;
        step();

        // Unauthorized exit on an empty lot saturates at zero.
        for (int i = 0; i < 12 && mcount > 0; i++) do_exit();
        exiting = 1'b1;
        step();
        exiting = 1'b0;
        chk("viol_empty", 32'(violation), 32'd1);
        chk("count_sat0", 32'(count), 32'd0);
        step();

        // Both pulses inside an entry grant at count 3.
        for (int i = 0; i < 4 && mcount < 3; i++) do_entry();
        req_in = 1'b1;
        step();
        req_in   = 1'b0;
        entering = 1'b1;
        exiting  = 1'b1;
        step();
        entering = 1'b0;
        exiting  = 1'b0;
        chk("both_count", 32'(count), 32'd3);
        step();

        // Asynchronous reset in the middle of an exit grant.
        for (int i = 0; i < 4 && mcount < 5; i++) do_entry();
        req_out = 1'b1;
        step();
        req_out = 1'b0;
        step();
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Random traffic; slow completions later to force timeouts.
        for (int i = 0; i < 3000; i++) begin
            pden = (i < 1500) ? 4 : 70;
            req_in  = ($urandom_range(0, 2) == 0);
            req_out = ($urandom_range(0, 3) == 0);
            if (owner == 1)
                entering = ($urandom_range(0, pden - 1) == 0);
            else
                entering = ($urandom_range(0, 39) == 0);
            if (owner == -1)
                exiting = ($urandom_range(0, pden - 1) == 0);
            else
                exiting = ($urandom_range(0, 39) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
